// File: rtl/ita_output_fifo.sv
// Output FIFO for the activation stage: tracks issued beats through a fixed-latency
// pipe, stores arriving data, and raises stall early enough that in-flight beats always fit.
module ita_output_fifo #(
    parameter int unsigned N       = 16,
    parameter int unsigned WI      = 8,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      valid_i,
    input  logic [N*WI-1:0]           data_i,
    output logic                      stall_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [N*WI-1:0]           data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o
);

    localparam int unsigned DW = N * WI;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = $clog2(LATENCY + 1);
    localparam int unsigned SW = CW + IW;

    logic [LATENCY-1:0] vsr_q;
    logic [PW-1:0]      wptr_q;
    logic [PW-1:0]      rptr_q;
    logic [CW-1:0]      count_q;
    logic               ovf_q;
    logic [DW-1:0]      mem [DEPTH];

    logic [IW-1:0]      inflight;
    logic               wr_en;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    // Occupancy bookkeeping; stall only looks at registered state.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            inflight = inflight + IW'(vsr_q[i]);
        end
        wr_en   = vsr_q[LATENCY-1];
        full    = (count_q == CW'(DEPTH));
        valid_o = (count_q != '0);
        pop     = valid_o && ready_i;
        push    = wr_en && (!full || pop);
        drop    = wr_en && full && !pop;
        stall_o = (SW'(count_q) + SW'(inflight)) >= SW'(DEPTH);
        data_o  = mem[rptr_q];
    end

    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsr_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (flush_i) begin
            vsr_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            vsr_q <= (vsr_q << 1) | LATENCY'(valid_i);
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if ((valid_i && stall_o) || drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wptr_q] <= data_i;
        end
    end

endmodule

// File: doc/ita_output_fifo.md
ITA_OUTPUT_FIFO -- requirements
Module: ita_output_fifo

Interface
REQ-001 Parameter N, default 16, number of output lanes per beat (matches ita_package N).
REQ-002 Parameter WI, default 8, bits per lane (requant_oup_t element width).
REQ-003 Parameter LATENCY, default 4, cycles from issue (valid_i) to data arrival on data_i; legal range 1..8.
REQ-004 Parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-005 clk_i  input  1  single clock; all state on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-007 flush_i  input  1  synchronous clear of FIFO, in-flight tracking and overflow flag.
REQ-008 valid_i  input  1  beat issued to the activation stage this cycle (issue-time qualifier).
REQ-009 data_i  input  N*WI  activation stage output; sampled exactly LATENCY cycles after the matching valid_i.
REQ-010 stall_o  output  1  upstream SHALL NOT assert valid_i while high.
REQ-011 valid_o  output  1  head entry available.
REQ-012 ready_i  input  1  downstream accepts head entry when valid_o and ready_i are both high.
REQ-013 data_o  output  N*WI  head entry; stable while valid_o high and ready_i low.
REQ-014 count_o  output  clog2(DEPTH)+1  entries currently stored.
REQ-015 overflow_o  output  1  sticky error flag.

Function
REQ-016 A LATENCY-deep valid shift register SHALL delay valid_i; its output is wr_en, and data_i is written to the tail when wr_en is high.
REQ-017 inflight SHALL equal the number of ones in the valid shift register (0..LATENCY).
REQ-018 stall_o SHALL be high when count_o + inflight >= DEPTH, computed combinationally from registered state only (no path from valid_i or ready_i).
REQ-019 A pop occurs when valid_o && ready_i; head pointer advances, data_o shows next entry the following cycle.
REQ-020 valid_o SHALL equal (count_o != 0); no bypass: a written beat is visible on valid_o one cycle after wr_en.
REQ-021 Simultaneous push and pop SHALL leave count_o unchanged and be legal at any occupancy, including full.
REQ-022 Read and write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-023 valid_i while stall_o high SHALL set overflow_o; the beat is still tracked in the shift register.
REQ-024 wr_en while count_o == DEPTH and no simultaneous pop SHALL drop the beat, leave FIFO contents unchanged and set overflow_o.
REQ-025 overflow_o SHALL remain high until reset or flush_i.
REQ-026 flush_i SHALL clear pointers, count_o, valid shift register and overflow_o at the next edge; wr_en, pop and valid_i in that cycle are discarded.
REQ-027 data_o SHALL be the storage entry at the read pointer; its value when valid_o is low is don't-care.

Reset
REQ-028 While rst_ni is low: count_o = 0, valid_o = 0, stall_o = 0, overflow_o = 0, pointers = 0, valid shift register = 0; storage is not reset.
REQ-029 Reset mid-operation SHALL discard stored and in-flight beats; data_i LATENCY cycles after a pre-reset valid_i SHALL NOT be written.
REQ-030 First valid_i is accepted in the first cycle after rst_ni deasserts.

Verification (DEPTH=4, LATENCY=4, N=16, WI=8)
REQ-031 One valid_i at cycle 0, data_i = lane k value k at cycle 4, ready_i high -> valid_o high at cycle 5 with data_o lanes 0..15, pops at cycle 5, count_o back to 0 at cycle 6.
REQ-032 ready_i low, valid_i on cycles 0..3 -> stall_o high from cycle 4 (inflight 4), count_o reaches 4 at cycle 8, stall_o stays high, overflow_o 0.
REQ-033 FIFO full, ready_i high for one cycle at the same edge as a wr_en -> count_o stays 4, popped entry is the oldest, new beat stored at wrapped tail.
REQ-034 Force valid_i while stall_o high with ready_i low -> overflow_o high next cycle; fifth beat dropped, count_o stays 4; flush_i clears overflow_o and count_o to 0.
REQ-035 Issue 3 beats, assert rst_ni low for one cycle at cycle 2 -> no beat ever appears on valid_o, count_o 0 throughout.
REQ-036 Random valid_i/ready_i obeying stall_o for 10000 cycles -> output order equals issue order, no loss, overflow_o never set.
